pipe_ctl_regs: RTL and testbench
================================

// Module: pipe_ctl_regs
// PURPOSE
// Parametrised pipeline-register chain with per-stage valid, stall and flush.
// Generalises the fixed flopr stage registers (IF_ID/ID_EX/EX_MEM/MEM_WB) to STAGES
// uniform W-bit stages. Stalled stages hold; bubbles enter behind them; flushed entries are killed.
// Sits between the datapath stages; the hazard unit drives stall_req/flush_req.
// PARAMETERS
// W       64  payload width per stage (bits)
// STAGES  4   number of register stages, >=1; stage 0 youngest, STAGES-1 oldest
// CNT_W   32  perf counter width (used only with PIPE_PERF_CNT_EN)
// PORTS
// clk          in   1          clock, rising edge
// reset        in   1          synchronous, active-high
// in_valid     in   1          payload on in_data is valid
// in_data      in   W          payload entering stage 0
// in_ready     out  1          stage 0 accepts this cycle (= ~hold[0])
// stall_req    in   STAGES     bit k: stage k must hold its entry
// flush_req    in   STAGES     bit k: kill entries in stages 0..k
// stage_valid  out  STAGES     valid bit per stage
// stage_data   out  STAGES*W   payload per stage, stage k at [k*W +: W]
// out_valid    out  1          = stage_valid[STAGES-1]
// out_data     out  W          = payload of stage STAGES-1
// BEHAVIOUR
// - hold[k] = |stall_req[STAGES-1:k] (a stall freezes stage k and all younger stages)
// - kill[k] = |flush_req[STAGES-1:k]; kill_in = |flush_req (incoming data is younger than stage 0)
// - Per clock edge, stage k (k>0):
//   kill[k] & hold[k]       -> valid<=0, data held
//   hold[k] & ~kill[k]      -> valid and data held
//   ~hold[k], hold[k-1]     -> valid<=0 (bubble), data don't-care
//   ~hold[k], ~hold[k-1]    -> valid<=stage_valid[k-1] & ~kill[k-1]; data<=stage k-1 data
// - Stage 0: ~hold[0] -> valid<=in_valid & ~kill_in, data<=in_data;
//   hold[0] -> valid<=valid & ~kill[0]
// - Flush beats stall at the same stage; killed entries never reach a later stage or out_valid
// - Oldest stage retires every cycle unless stall_req[STAGES-1] is high
//   (no downstream ready; the consumer stalls via stall_req)
// - in_ready is combinational from stall_req only, independent of in_valid/flush
// - Latency: accepted entry is out_valid exactly STAGES cycles after acceptance edge, with no stall/flush
// - Throughput 1/cycle; the stall of stage k inserts one bubble per stalled cycle at stage k+1
// - reset: all stage_valid=0, all stage_data=0, out_valid=0, out_data=0;
//   reset mid-stream discards all entries
// - reset dominates stall/flush; in_ready still follows stall_req during reset
// - STAGES=1: stage 0 is both entry and exit; rules above apply unchanged
// - Data registers load only when not held; no X propagation from bubble stages
// CONFIGURATION
// PIPE_PERF_CNT_EN defined: adds outputs perf_retired, perf_bubbles, perf_stalls (CNT_W each, out)
// - perf_retired +1 per cycle out_valid & ~stall_req[STAGES-1]
// - perf_bubbles +1 per cycle out_valid=0
// - perf_stalls  +1 per cycle in_ready=0
// - all counters saturate at all-ones and reset to 0
// PIPE_PERF_CNT_EN undefined: ports and counter logic absent; core behaviour identical
// TESTING (W=64, STAGES=4 unless noted)
// - Stream 1..8 valid every cycle, no stall -> out_data 1..8 on consecutive cycles;
//   first out_valid 4 cycles after accepting 1
// - Pipe full {s3..s0}={1,2,3,4}, stall_req=4'b0010 two cycles -> in_ready=0; s0,s1 hold 4,3;
//   s2 bubbles; out gives 1,2,gap,gap,3,4
// - Pipe full, flush_req=4'b0100 with in_valid=1 (data 9) -> 1 retires; next cycle stage_valid=4'b0000;
//   9 dropped
// - stall_req=4'b0001 and flush_req=4'b0001 same cycle -> stage_valid[0]<=0; in_ready=0; stages 1..3 advance
// - reset asserted mid-stream with 3 valid entries -> next edge stage_valid=0, out_data=0;
//   after release, 1-cycle input reappears after 4 cycles
// - PIPE_PERF_CNT_EN, 10 accepts, 2 stalled cycles, drain -> perf_retired=10,
//   perf_stalls=2, perf_bubbles=cycles with out_valid=0

Source files
------------

// File: rtl/pipe_ctl_regs_if.sv
// pipe_ctl_regs_if: input, control and per-stage output bundle for pipe_ctl_regs
// The perf counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_ctl_regs_if #(
    parameter int W = 64,
    parameter int STAGES = 4
`ifdef PIPE_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
);
    logic                  in_valid;
    logic [W-1:0]          in_data;
    logic                  in_ready;
    logic [STAGES-1:0]     stall_req;
    logic [STAGES-1:0]     flush_req;
    logic [STAGES-1:0]     stage_valid;
    logic [STAGES*W-1:0]   stage_data;
    logic                  out_valid;
    logic [W-1:0]          out_data;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]      perf_retired;
    logic [CNT_W-1:0]      perf_bubbles;
    logic [CNT_W-1:0]      perf_stalls;
`endif
    modport master (
        output in_valid, in_data, stall_req, flush_req,
        input  in_ready, stage_valid, stage_data, out_valid, out_data
`ifdef PIPE_PERF_CNT_EN
        , input perf_retired, perf_bubbles, perf_stalls
`endif
    );
    modport slave (
        input  in_valid, in_data, stall_req, flush_req,
        output in_ready, stage_valid, stage_data, out_valid, out_data
`ifdef PIPE_PERF_CNT_EN
        , output perf_retired, perf_bubbles, perf_stalls
`endif
    );
endinterface

// File: rtl/pipe_ctl_regs.sv
// pipe_ctl_regs: STAGES-deep pipeline register chain with per-stage valid, stall and flush
// Defining PIPE_PERF_CNT_EN adds saturating retired/bubble/stall counters.
module pipe_ctl_regs #(
    parameter int W = 64,
    parameter int STAGES = 4
`ifdef PIPE_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input logic            clk,
    input logic            reset,
    pipe_ctl_regs_if.slave bus
);
    logic [STAGES-1:0]        hold, kill, valid_q, valid_d;
    logic [STAGES-1:0][W-1:0] data_q, data_d;
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign hold[k] = |bus.stall_req[STAGES-1:k];
        assign kill[k] = |bus.flush_req[STAGES-1:k];
        if (k == 0) begin : g_head
            // Incoming data is younger than stage 0, so any flush kills it (kill[0] == |flush_req).
            assign valid_d[k] = hold[k] ? valid_q[k] & ~kill[k] : bus.in_valid & ~kill[k];
            assign data_d[k]  = hold[k] ? data_q[k] : bus.in_data;
        end else begin : g_body
            assign valid_d[k] = hold[k] ? valid_q[k] & ~kill[k] : ~hold[k-1] & valid_q[k-1] & ~kill[k-1];
            assign data_d[k]  = hold[k] ? data_q[k] : data_q[k-1];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign bus.in_ready    = ~hold[0];
    assign bus.stage_valid = valid_q;
    assign bus.stage_data  = data_q;
    assign bus.out_valid   = valid_q[STAGES-1];
    assign bus.out_data    = data_q[STAGES-1];
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] ret_q, ret_d, bub_q, bub_d, stl_q, stl_d;
    // Each counter sticks at all-ones instead of wrapping.
    assign ret_d = ret_q + CNT_W'(valid_q[STAGES-1] & ~bus.stall_req[STAGES-1] & ~&ret_q);
    assign bub_d = bub_q + CNT_W'(~valid_q[STAGES-1] & ~&bub_q);
    assign stl_d = stl_q + CNT_W'(hold[0] & ~&stl_q);
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_q <= '0;
            bub_q <= '0;
            stl_q <= '0;
        end else begin
            ret_q <= ret_d;
            bub_q <= bub_d;
            stl_q <= stl_d;
        end
    end
    assign bus.perf_retired = ret_q;
    assign bus.perf_bubbles = bub_q;
    assign bus.perf_stalls  = stl_q;
`endif
endmodule

// File: tb/tb_pipe_ctl_regs.sv
// tb_pipe_ctl_regs: scoreboard bench for pipe_ctl_regs (W=64, STAGES=4); perf checks when PIPE_PERF_CNT_EN
module tb_pipe_ctl_regs;
    localparam int W = 64;
    localparam int S = 4;
    typedef struct {
        int           c;
        logic [W-1:0] d;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int m_ret = 0, m_bub = 0, m_stl = 0;
    exp_t sb[$];
    pipe_ctl_regs_if #(.W(W), .STAGES(S)) bus();
    pipe_ctl_regs #(.W(W), .STAGES(S)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic expect_at(input int c, input logic [W-1:0] d);
        exp_t e;
        e.c = c;
        e.d = d;
        sb.push_back(e);
    endtask
    task automatic put(input logic iv, input logic [W-1:0] d, input logic [S-1:0] st, input logic [S-1:0] fl);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.stall_req = st;
        bus.flush_req = fl;
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        put(1'b0, '0, '0, '0);
        repeat (n) tick;
    endtask
    task automatic fill;
        for (int i = 1; i <= S; i++) begin
            put(1'b1, W'(i), '0, '0);
            tick;
        end
    endtask
    // Scoreboard: every valid output must match the oldest expectation in data and arrival cycle.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (sb.size() == 0) chk("unexpected_out", bus.out_data, '0 - 1);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", bus.out_data, e.d);
                chk("out_cycle", W'(cyc), W'(e.c));
            end
        end
        if (reset) begin
            m_ret = 0;
            m_bub = 0;
            m_stl = 0;
        end else begin
            m_ret += int'(bus.out_valid & ~bus.stall_req[S-1]);
            m_bub += int'(~bus.out_valid);
            m_stl += int'(~bus.in_ready);
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int c0;
        put(1'b0, '0, '0, '0);
        repeat (2) tick;
        chk("rst_stage_valid", W'(bus.stage_valid), '0);
        chk("rst_stage_data_zero", W'(bus.stage_data == '0), 1);
        chk("rst_out_valid", W'(bus.out_valid), 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_in_ready", W'(bus.in_ready), 1);
        reset = 1'b0;
        c0 = cyc;
        for (int i = 1; i <= 8; i++) begin
            expect_at(cyc + S, W'(i));
            put(1'b1, W'(i), '0, '0);
            tick;
        end
        idle(6);
        chk("stream_drained", W'(sb.size()), 0);
        c0 = cyc;
        fill;
        expect_at(c0 + 4, 1);
        expect_at(c0 + 5, 2);
        expect_at(c0 + 8, 3);
        expect_at(c0 + 9, 4);
        put(1'b0, '0, 4'b0010, '0);
        #1 chk("stall_in_ready", W'(bus.in_ready), 0);
        tick;
        chk("stall_valid_1", W'(bus.stage_valid), W'(4'b1011));
        tick;
        chk("stall_valid_2", W'(bus.stage_valid), W'(4'b0011));
        chk("stall_s0_data", bus.stage_data[0*W +: W], 4);
        chk("stall_s1_data", bus.stage_data[1*W +: W], 3);
        idle(6);
        chk("stall_drained", W'(sb.size()), 0);
        c0 = cyc;
        fill;
        expect_at(c0 + 4, 1);
        put(1'b1, 9, '0, 4'b0100);
        #1 chk("flush_in_ready", W'(bus.in_ready), 1);
        tick;
        chk("flush_valid", W'(bus.stage_valid), 0);
        idle(5);
        chk("flush_drained", W'(sb.size()), 0);
        c0 = cyc;
        fill;
        expect_at(c0 + 4, 1);
        expect_at(c0 + 5, 2);
        expect_at(c0 + 6, 3);
        put(1'b1, 9, 4'b0001, 4'b0001);
        #1 chk("sf_in_ready", W'(bus.in_ready), 0);
        tick;
        chk("sf_valid", W'(bus.stage_valid), W'(4'b1100));
        chk("sf_s3_data", bus.stage_data[3*W +: W], 2);
        idle(5);
        chk("sf_drained", W'(sb.size()), 0);
        for (int i = 1; i <= 3; i++) begin
            put(1'b1, W'(i), '0, '0);
            tick;
        end
        reset = 1'b1;
        put(1'b1, 7, 4'b0001, '0);
        #1 chk("rst_mid_in_ready", W'(bus.in_ready), 0);
        tick;
        chk("rst_mid_valid", W'(bus.stage_valid), 0);
        chk("rst_mid_out_data", bus.out_data, 0);
        chk("rst_mid_data_zero", W'(bus.stage_data == '0), 1);
        reset = 1'b0;
        expect_at(cyc + S, 64'h55);
        put(1'b1, 64'h55, '0, '0);
        tick;
        idle(7);
        chk("final_drained", W'(sb.size()), 0);
`ifdef PIPE_PERF_CNT_EN
        chk("perf_retired", W'(bus.perf_retired), W'(m_ret));
        chk("perf_bubbles", W'(bus.perf_bubbles), W'(m_bub));
        chk("perf_stalls", W'(bus.perf_stalls), W'(m_stl));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
